// File: rtl/gpio_pkg.sv
// Shared constants and types for the GPIO input debounce stage.
package gpio_pkg;

  localparam int GPIO_W         = 32;
  localparam int CNT_W_DEF      = 4;
  localparam int PRESCALE_W_DEF = 16;

  // What one filter bit does on a given cycle.
  typedef enum logic [2:0] {
    ACT_HOLD,
    ACT_BYPASS,
    ACT_CLEAR,
    ACT_COUNT,
    ACT_ACCEPT
  } db_act_e;

endpackage

// File: rtl/gpio_db_bit.sv
// One bit of the debounce filter: stability counter, threshold compare and output flop.
module gpio_db_bit
  import gpio_pkg::*;
#(
  parameter int CNT_W = CNT_W_DEF
) (
  input  logic             PCLK,
  input  logic             PRESETn,
  input  logic             tick,
  input  logic [CNT_W-1:0] thr,
  input  logic             en,
  input  logic             sync,
  output logic             level
);

  logic [CNT_W-1:0] cnt;
  logic [CNT_W:0]   cnt_inc;
  db_act_e          act;

  assign cnt_inc = {1'b0, cnt} + (CNT_W + 1)'(1);

  always_comb begin
    act = ACT_HOLD;
    if (!en) begin
      act = ACT_BYPASS;
    end else if (sync == level) begin
      act = ACT_CLEAR;
    end else if (tick) begin
      // thr may have been lowered below a running count; >= accepts at once
      if (cnt_inc >= {1'b0, thr}) act = ACT_ACCEPT;
      else                        act = ACT_COUNT;
    end
  end

  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      cnt   <= '0;
      level <= 1'b0;
    end else begin
      case (act)
        ACT_BYPASS: begin
          cnt   <= '0;
          level <= sync;
        end
        ACT_CLEAR:  cnt <= '0;
        ACT_COUNT:  cnt <= cnt_inc[CNT_W-1:0];
        ACT_ACCEPT: begin
          cnt   <= '0;
          level <= sync;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/gpio_32_debounce.sv
// 32-bit pad synchroniser, shared tick prescaler and per-bit debounce filters.
// Define GPIO_DB_SYNC3_EN for a three-stage synchroniser (adds one cycle of latency).
module gpio_32_debounce
  import gpio_pkg::*;
#(
  parameter int CNT_W      = CNT_W_DEF,
  parameter int PRESCALE_W = PRESCALE_W_DEF
) (
  input  logic                  PCLK,
  input  logic                  PRESETn,
  input  logic [GPIO_W-1:0]     gpio_in,
  input  logic [GPIO_W-1:0]     db_en,
  input  logic [PRESCALE_W-1:0] db_prescale,
  input  logic [CNT_W-1:0]      db_threshold,
  output logic [GPIO_W-1:0]     gpio_sync,
  output logic [GPIO_W-1:0]     debounced_gpio_in
);

  logic [GPIO_W-1:0]     sync1;
  logic [GPIO_W-1:0]     sync2;
  logic [PRESCALE_W-1:0] pcnt;
  logic                  tick;
  logic [CNT_W-1:0]      thr;

`ifdef GPIO_DB_SYNC3_EN
  logic [GPIO_W-1:0] sync3;

  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      sync1 <= '0;
      sync2 <= '0;
      sync3 <= '0;
    end else begin
      sync1 <= gpio_in;
      sync2 <= sync1;
      sync3 <= sync2;
    end
  end

  assign gpio_sync = sync3;
`else
  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      sync1 <= '0;
      sync2 <= '0;
    end else begin
      sync1 <= gpio_in;
      sync2 <= sync1;
    end
  end

  assign gpio_sync = sync2;
`endif

  // >= rather than == so lowering db_prescale below pcnt ticks next cycle instead of wrapping
  assign tick = (pcnt >= db_prescale);

  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      pcnt <= '0;
    end else if (tick) begin
      pcnt <= '0;
    end else begin
      pcnt <= pcnt + PRESCALE_W'(1);
    end
  end

  assign thr = (db_threshold == '0) ? CNT_W'(1) : db_threshold;

  for (genvar i = 0; i < GPIO_W; i++) begin : g_bit
    gpio_db_bit #(
      .CNT_W (CNT_W)
    ) u_bit (
      .PCLK    (PCLK),
      .PRESETn (PRESETn),
      .tick    (tick),
      .thr     (thr),
      .en      (db_en[i]),
      .sync    (gpio_sync[i]),
      .level   (debounced_gpio_in[i])
    );
  end

endmodule

// File: doc/gpio_32_debounce.md
# gpio_32_debounce

32-bit input conditioning stage that sits directly upstream of the GPIO interrupt controller and drives its `debounced_gpio_in` bus. It synchronises asynchronous pad inputs into the PCLK domain, then applies a per-bit debounce filter against a shared prescaled tick. An output bit changes only after its synchronised input has held a new value for a programmable number of ticks. Bits with filtering disabled pass straight through after synchronisation.

## Interface
Parameters:
- `CNT_W`, default 4: width of the per-bit stability counter and of `db_threshold`.
- `PRESCALE_W`, default 16: width of the shared tick prescaler and of `db_prescale`.

Ports:
- `PCLK` — input, 1 bit. Clock.
- `PRESETn` — input, 1 bit. Reset; asynchronous, active-low.
- `gpio_in` — input, 32 bits. Raw pad inputs, asynchronous to PCLK.
- `db_en` — input, 32 bits. Per-bit debounce enable; 1 = filtered, 0 = bypass.
- `db_prescale` — input, `PRESCALE_W` bits. The tick fires every `db_prescale+1` PCLK cycles.
- `db_threshold` — input, `CNT_W` bits. Number of consecutive mismatching ticks required before the output accepts a new value; 0 is treated as 1.
- `gpio_sync` — output, 32 bits. Synchronised raw inputs, used for DATA_IN reads.
- `debounced_gpio_in` — output, 32 bits. Filtered inputs, fed to the interrupt controller.

## Operation
- **Reset:** all synchroniser flops, the prescaler, all counters, `gpio_sync` and `debounced_gpio_in` reset to 0.
  - A pin held high through reset therefore produces a 0→1 transition on `debounced_gpio_in` after reset release.
  - This is intended: the interrupt controller sees it as a rising edge.
- **Synchroniser:**
  - Two flops per bit.
  - `gpio_sync` is the output of the last flop.
- **Prescaler:**
  - Free-running counter `pcnt`.
  - When `pcnt >= db_prescale`: `tick` = 1 for that cycle and `pcnt` goes to 0 on the next edge; otherwise `pcnt` increments.
  - `db_prescale` = 0 gives a tick every cycle.
  - If `db_prescale` is lowered below the current `pcnt`, the next cycle ticks. No wrap to the full range occurs.
- **Per bit i, `db_en[i]` = 0 (bypass):**
  - `debounced_gpio_in[i] <= gpio_sync[i]` every cycle.
  - `cnt[i]` is held at 0.
- **Per bit i, `db_en[i]` = 1 (filtered):**
  - If `gpio_sync[i] == debounced_gpio_in[i]`: `cnt[i] <= 0`, on any cycle, tick or not.
  - Else, on a tick cycle, let `thr = max(db_threshold, 1)`:
    - If `cnt[i]+1 >= thr`: `debounced_gpio_in[i] <= gpio_sync[i]` and `cnt[i] <= 0`.
    - Otherwise: `cnt[i] <= cnt[i]+1`.
  - Else, on a non-tick cycle: `cnt[i]` holds.
  - The counter never exceeds `thr-1`, so no saturation logic is needed.
- **`db_en[i]` 1→0 mid-count:**
  - The counter clears.
  - The output follows `gpio_sync` from the next edge.
- **`db_en[i]` 0→1:** filtering starts with `cnt` = 0.
- **`db_threshold` changed mid-count:** the new value applies at the next tick. A count already at or above the new threshold accepts on that tick.
- **Independence:** all 32 bits are independent and share only `tick`.

## Timing
Let P = `db_prescale` and N = `max(db_threshold, 1)`. Edge 1 is the first PCLK edge after a `gpio_in` change.
- `gpio_sync` changes at edge 2.
- Bypass: `debounced_gpio_in` changes at edge 3.
- Filtered, input held stable: the output changes at an edge in the range [2+(N-1)(P+1)+1, 2+N(P+1)]. The exact edge depends on tick phase.
- Pulses shorter than (N-1)(P+1)+1 cycles after synchronisation never reach the output.
- There is no handshake. The output is registered and changes at most once per tick per bit in filtered mode.

## Configuration
- `GPIO_DB_SYNC3_EN` defined:
  - A third synchroniser stage is inserted per bit.
  - `gpio_sync` and every latency above increase by exactly 1 cycle.
- `GPIO_DB_SYNC3_EN` undefined: two-stage synchroniser, as specified above.

## Structure
- Shared package `gpio_pkg` holds:
  - `GPIO_W = 32`.
  - Default `CNT_W` and `PRESCALE_W` constants.
- Sub-module `gpio_db_bit`:
  - Contains one bit's filter: counter, compare and output flop.
  - Inputs: `tick`, `thr`, `en`, `sync`.
  - Instantiated `GPIO_W` times in a generate loop.
  - The top level holds the synchroniser and the prescaler.

## Test plan
- **Reset value:** `gpio_in` = 0xFFFF_FFFF, `db_en` = 0 held through reset → both outputs are 0 in reset. `gpio_sync` = all-ones at edge 2 and `debounced_gpio_in` = all-ones at edge 3 after release.
- **Filtered rise:** P=3, N=4, `db_en[0]`=1, `gpio_in[0]` 0→1 held → `debounced_gpio_in[0]` rises between edges 15 and 18, never earlier.
- **Glitch rejection:** P=3, N=4, `gpio_in[5]` high for 8 cycles, then low → `debounced_gpio_in[5]` stays 0. `cnt[5]` returns to 0 once `gpio_sync[5]` is low again.
- **Threshold zero:** P=0, N=0, `db_en[7]`=1, toggle `gpio_in[7]` → behaves as N=1. The output follows at edge 3, same as bypass.
- **Enable change mid-count:** P=9, N=8, `gpio_in[2]` rises, then `db_en[2]` 1→0 after 20 cycles → output rises on the edge after the enable drop.
- **Macro:** repeat the filtered-rise scenario with `GPIO_DB_SYNC3_EN` defined → the window becomes edges 16 to 19, and the bypass latency becomes edge 4.
